apb_io_regs: RTL and testbench

APB3 slave register block exposing a small fixed register map: three read-only status inputs, three read/write control outputs (32/16/8 bit) and a constant ID word. It sits on the peripheral APB bus behind the bridge and connects software to block-level status and control wiring. Zero-wait-state access when clocked. Clock gating is applied via `clk_en`.

---
 rtl/apb_io_regs_pkg.sv | 40 ++++
 rtl/apb_io_regs.sv | 107 ++++++++++
 tb/tb_apb_io_regs.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/apb_io_regs_pkg.sv
// Shared constants for the apb_io_regs register block: address map,
// register reset values and the constant ID word.
package apb_io_regs_pkg;

  localparam logic [4:0] ADDR_STATUS32 = 5'h00;
  localparam logic [4:0] ADDR_STATUS16 = 5'h04;
  localparam logic [4:0] ADDR_STATUS8  = 5'h08;
  localparam logic [4:0] ADDR_RSVD     = 5'h0C;
  localparam logic [4:0] ADDR_CTRL32   = 5'h10;
  localparam logic [4:0] ADDR_CTRL16   = 5'h14;
  localparam logic [4:0] ADDR_CTRL8    = 5'h18;
  localparam logic [4:0] ADDR_ID       = 5'h1C;

  localparam logic [31:0] RST_CTRL32 = 32'h0000_0000;
  localparam logic [15:0] RST_CTRL16 = 16'h1234;
  localparam logic [7:0]  RST_CTRL8  = 8'h00;

  // "Hi!" stored little-endian.
  localparam logic [31:0] ID_WORD = 32'h0021_6948;

  typedef enum logic [2:0] {
    IDX_STATUS32 = ADDR_STATUS32[4:2],
    IDX_STATUS16 = ADDR_STATUS16[4:2],
    IDX_STATUS8  = ADDR_STATUS8[4:2],
    IDX_RSVD     = ADDR_RSVD[4:2],
    IDX_CTRL32   = ADDR_CTRL32[4:2],
    IDX_CTRL16   = ADDR_CTRL16[4:2],
    IDX_CTRL8    = ADDR_CTRL8[4:2],
    IDX_ID       = ADDR_ID[4:2]
  } reg_idx_e;

  function automatic reg_idx_e addr_to_idx(input logic [4:0] addr);
    return reg_idx_e'(addr[4:2]);
  endfunction

  function automatic logic idx_is_ro(input reg_idx_e idx);
    return !(idx inside {IDX_CTRL32, IDX_CTRL16, IDX_CTRL8});
  endfunction

endpackage

// File: rtl/apb_io_regs.sv
// APB3 slave exposing three status inputs, three control registers and an ID
// word. Zero wait states; clk_en freezes all state and stretches the access.
module apb_io_regs
  import apb_io_regs_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 5,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      clk_en,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [31:0]               status32b_i,
  input  logic [15:0]               status16b_i,
  input  logic [7:0]                status8b_i,
  output logic [31:0]               control32b_o,
  output logic [15:0]               control16b_o,
  output logic [7:0]                control8b_o
);

  reg_idx_e    word_idx;
  logic        addr_is_ro;
  logic        apb_write_access;
  logic        apb_read_setup;
  logic [31:0] rdata_mux;

  logic [31:0] ctrl32_q, ctrl32_d;
  logic [15:0] ctrl16_q, ctrl16_d;
  logic [7:0]  ctrl8_q,  ctrl8_d;
  logic [31:0] prdata_q, prdata_d;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^PADDR[1:0];

  assign word_idx         = addr_to_idx(PADDR[4:0]);
  assign addr_is_ro       = idx_is_ro(word_idx);
  assign apb_write_access = PSEL & PENABLE & PWRITE & clk_en;
  assign apb_read_setup   = PSEL & ~PENABLE & ~PWRITE & clk_en;

  always_comb begin
    rdata_mux = 32'h0;
    unique case (word_idx)
      IDX_STATUS32: rdata_mux = status32b_i;
      IDX_STATUS16: rdata_mux = {16'h0, status16b_i};
      IDX_STATUS8:  rdata_mux = {24'h0, status8b_i};
      IDX_RSVD:     rdata_mux = 32'h0;
      IDX_CTRL32:   rdata_mux = ctrl32_q;
      IDX_CTRL16:   rdata_mux = {16'h0, ctrl16_q};
      IDX_CTRL8:    rdata_mux = {24'h0, ctrl8_q};
      IDX_ID:       rdata_mux = ID_WORD;
      default:      rdata_mux = 32'h0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    ctrl32_d = ctrl32_q;
    ctrl16_d = ctrl16_q;
    ctrl8_d  = ctrl8_q;
    prdata_d = prdata_q;
    if (apb_write_access) begin
      unique case (word_idx)
        IDX_CTRL32: ctrl32_d = PWDATA[31:0];
        IDX_CTRL16: ctrl16_d = PWDATA[15:0];
        IDX_CTRL8:  ctrl8_d  = PWDATA[7:0];
        default:    ;
      endcase
    end
    if (apb_read_setup) begin
      prdata_d = rdata_mux;
    end
  end

  // NOTE: reset is tested before clk_en so it wins even while the clock is
  // gated; state updates use non-blocking assignments so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl32_q <= RST_CTRL32;
      ctrl16_q <= RST_CTRL16;
      ctrl8_q  <= RST_CTRL8;
      prdata_q <= 32'h0;
    end else if (clk_en) begin
      ctrl32_q <= ctrl32_d;
      ctrl16_q <= ctrl16_d;
      ctrl8_q  <= ctrl8_d;
      prdata_q <= prdata_d;
    end
  end

  assign PRDATA       = prdata_q;
  assign PREADY       = clk_en;
  assign PSLVERR      = PSEL & PENABLE & PWRITE & addr_is_ro;
  assign control32b_o = ctrl32_q;
  assign control16b_o = ctrl16_q;
  assign control8b_o  = ctrl8_q;

endmodule

// File: tb/tb_apb_io_regs.sv
// Directed self-checking bench for apb_io_regs: register map, RO write
// errors, clock-enable stretching and reset during a write.
module tb_apb_io_regs;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        clk_en;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] status32b_i;
  logic [15:0] status16b_i;
  logic [7:0]  status8b_i;
  logic [31:0] control32b_o;
  logic [15:0] control16b_o;
  logic [7:0]  control8b_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe_viol = 0;

  always #5 PCLK = ~PCLK;

  apb_io_regs #(.APB_ADDR_WIDTH(5), .APB_DATA_WIDTH(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .clk_en(clk_en),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .status32b_i(status32b_i), .status16b_i(status16b_i), .status8b_i(status8b_i),
    .control32b_o(control32b_o), .control16b_o(control16b_o), .control8b_o(control8b_o)
  );

  // Write strobe must only ever fire in an enabled write access phase.
  always @(negedge PCLK) begin
    if (dut.apb_write_access && !(PSEL && PENABLE && PWRITE && clk_en))
      n_strobe_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives setup then access; returns PSLVERR sampled mid access phase.
  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data,
                           output logic slverr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic slverr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data   = PRDATA;
    slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic [4:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    string       tag;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_vec_t;

  initial begin
    logic [31:0] rd;
    logic        err;
    rd_vec_t reset_reads[6];
    wr_vec_t writes[3];
    rd_vec_t post_reads[5];

    reset_reads[0] = '{"rd_status32", 5'h00, 32'h9c4e_9a31};
    reset_reads[1] = '{"rd_status16", 5'h04, 32'h0000_7832};
    reset_reads[2] = '{"rd_status8",  5'h08, 32'h0000_002a};
    reset_reads[3] = '{"rd_ctrl16_rst", 5'h14, 32'h0000_1234};
    reset_reads[4] = '{"rd_ctrl32_rst", 5'h10, 32'h0000_0000};
    reset_reads[5] = '{"rd_ctrl8_rst",  5'h18, 32'h0000_0000};

    // Upper PWDATA bits on the narrow registers must be dropped.
    writes[0] = '{"wr_ctrl32", 5'h10, 32'h1122_3344};
    writes[1] = '{"wr_ctrl16", 5'h14, 32'hCAFE_AABB};
    writes[2] = '{"wr_ctrl8",  5'h18, 32'h1234_56DD};

    post_reads[0] = '{"rb_ctrl32", 5'h10, 32'h1122_3344};
    post_reads[1] = '{"rb_ctrl16", 5'h14, 32'h0000_AABB};
    post_reads[2] = '{"rb_ctrl8",  5'h18, 32'h0000_00DD};
    post_reads[3] = '{"rd_id",     5'h1C, 32'h0021_6948};
    post_reads[4] = '{"rd_rsvd",   5'h0F, 32'h0000_0000};

    PRESET = 1'b1; clk_en = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    status32b_i = 32'h9c4e_9a31; status16b_i = 16'h7832; status8b_i = 8'h2a;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_ctrl32", control32b_o, 32'h0);
    check("rst_ctrl16", {16'h0, control16b_o}, 32'h0000_1234);
    check("rst_ctrl8",  {24'h0, control8b_o}, 32'h0);
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    @(posedge PCLK); #1;

    foreach (reset_reads[i]) begin
      apb_read(reset_reads[i].addr, rd, err);
      check(reset_reads[i].tag, rd, reset_reads[i].exp);
    end
    check("rd_no_slverr", {31'h0, err}, 32'h0);

    // Tasks chain with no idle cycle, so these writes are back-to-back.
    foreach (writes[i]) begin
      apb_write(writes[i].addr, writes[i].data, err);
      check({writes[i].tag, "_slverr"}, {31'h0, err}, 32'h0);
    end
    check("out_ctrl32", control32b_o, 32'h1122_3344);
    check("out_ctrl16", {16'h0, control16b_o}, 32'h0000_AABB);
    check("out_ctrl8",  {24'h0, control8b_o}, 32'h0000_00DD);

    foreach (post_reads[i]) begin
      apb_read(post_reads[i].addr, rd, err);
      check(post_reads[i].tag, rd, post_reads[i].exp);
    end

    apb_write(5'h00, 32'hFFFF_FFFF, err);
    check("ro_status_slverr", {31'h0, err}, 32'h1);
    apb_write(5'h1C, 32'hFFFF_FFFF, err);
    check("ro_id_slverr", {31'h0, err}, 32'h1);
    apb_read(5'h00, rd, err);
    check("ro_status_unchanged", rd, 32'h9c4e_9a31);
    apb_read(5'h1C, rd, err);
    check("ro_id_unchanged", rd, 32'h0021_6948);
    check("ro_ctrl32_unchanged", control32b_o, 32'h1122_3344);
    check("ro_ctrl16_unchanged", {16'h0, control16b_o}, 32'h0000_AABB);
    check("ro_ctrl8_unchanged",  {24'h0, control8b_o}, 32'h0000_00DD);

    // Access phase held with clk_en low for three edges.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h14; PWDATA = 32'h0000_5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    clk_en  = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("gate_pready", {31'h0, PREADY}, 32'h0);
    check("gate_ctrl16_held", {16'h0, control16b_o}, 32'h0000_AABB);
    check("gate_prdata_held", PRDATA, 32'h0021_6948);
    clk_en = 1'b1;
    @(negedge PCLK);
    check("ungate_pready", {31'h0, PREADY}, 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("ungate_ctrl16", {16'h0, control16b_o}, 32'h0000_5555);

    apb_read(5'h10, rd, err);
    check("pre_reset_rd", rd, 32'h1122_3344);

    // Reset lands on the edge that would have completed this write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h14; PWDATA = 32'h0000_7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PRESET  = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    check("midrst_ctrl16", {16'h0, control16b_o}, 32'h0000_1234);
    check("midrst_ctrl32", control32b_o, 32'h0);
    check("midrst_prdata", PRDATA, 32'h0);

    check("strobe_violations", n_strobe_viol, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
